// File: rtl/mfcc_dct_pkg.sv
// Shared widths, typedefs and quarter-wave cosine table for the 32-in / 13-out
// MFCC DCT-II. The table holds round(127*cos(pi*j/64)) for j = 0..32.
package mfcc_dct_pkg;

  localparam int I_BW     = 8;
  localparam int O_BW     = 16;
  localparam int N_IN     = 32;
  localparam int NUM_COEF = 13;
  localparam int COEF_BW  = 8;
  localparam int SHIFT    = 4;
  localparam int ACC_BW   = I_BW + COEF_BW + $clog2(N_IN) + 1;
  localparam int N_BW     = $clog2(N_IN);
  // One extra code so the drain index can point one past the last coefficient.
  localparam int K_BW     = $clog2(NUM_COEF + 1);

  typedef logic signed [COEF_BW-1:0] coef_t;
  typedef logic signed [ACC_BW-1:0]  acc_t;

  typedef enum logic {
    DRAIN_IDLE,
    DRAIN_BUSY
  } drain_state_e;

  function automatic coef_t cos_quarter(input logic [5:0] j);
    coef_t c;
    case (j)
      6'd0:  c = 8'sd127;  6'd1:  c = 8'sd127;  6'd2:  c = 8'sd126;
      6'd3:  c = 8'sd126;  6'd4:  c = 8'sd125;  6'd5:  c = 8'sd123;
      6'd6:  c = 8'sd122;  6'd7:  c = 8'sd120;  6'd8:  c = 8'sd117;
      6'd9:  c = 8'sd115;  6'd10: c = 8'sd112;  6'd11: c = 8'sd109;
      6'd12: c = 8'sd106;  6'd13: c = 8'sd102;  6'd14: c = 8'sd98;
      6'd15: c = 8'sd94;   6'd16: c = 8'sd90;   6'd17: c = 8'sd85;
      6'd18: c = 8'sd81;   6'd19: c = 8'sd76;   6'd20: c = 8'sd71;
      6'd21: c = 8'sd65;   6'd22: c = 8'sd60;   6'd23: c = 8'sd54;
      6'd24: c = 8'sd49;   6'd25: c = 8'sd43;   6'd26: c = 8'sd37;
      6'd27: c = 8'sd31;   6'd28: c = 8'sd25;   6'd29: c = 8'sd19;
      6'd30: c = 8'sd12;   6'd31: c = 8'sd6;    6'd32: c = 8'sd0;
      default: c = 8'sd0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mfcc_dct_coef_rom.sv
// Combinational C[k][n] = round(127*cos(pi*k*(2n+1)/64)) lookup, folded onto
// the quarter-wave table using the 128-step period and half-wave symmetry.
module mfcc_dct_coef_rom
  import mfcc_dct_pkg::*;
(
  input  logic [K_BW-1:0]    i_k,
  input  logic [N_BW-1:0]    i_n,
  output logic [COEF_BW-1:0] o_coef
);

  logic [6:0] w_m;
  logic [6:0] w_fold;
  logic       w_neg;
  logic [5:0] w_idx;
  coef_t      w_q;

  // Phase in units of pi/64, taken modulo a full period of 128.
  assign w_m    = 7'(7'(i_k) * 7'({i_n, 1'b1}));
  assign w_fold = (w_m > 7'd64) ? (7'd0 - w_m) : w_m;
  assign w_neg  = (w_fold > 7'd32);
  assign w_idx  = w_neg ? 6'(7'd64 - w_fold) : w_fold[5:0];
  assign w_q    = cos_quarter(w_idx);
  assign o_coef = w_neg ? -w_q : w_q;

endmodule

// File: rtl/mfcc_dct.sv
// Streaming 32-point DCT-II producing 13 MFCC coefficients with one shared MAC.
// Define MFCC_DCT_SAT_EN to saturate outputs instead of wrapping to O_BW bits.
module mfcc_dct
  import mfcc_dct_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic [I_BW-1:0] data_i,
  input  logic            valid_i,
  input  logic            last_i,
  output logic [O_BW-1:0] data_o,
  output logic            valid_o,
  output logic            last_o
);

  localparam logic [K_BW-1:0] K_LAST = K_BW'(NUM_COEF - 1);
  localparam logic [K_BW-1:0] K_DONE = K_BW'(NUM_COEF);
  localparam logic [N_BW-1:0] N_LAST = N_BW'(N_IN - 1);

`ifdef MFCC_DCT_SAT_EN
  localparam acc_t OUT_MAX = acc_t'((2 ** (O_BW - 1)) - 1);
  localparam acc_t OUT_MIN = acc_t'(-(2 ** (O_BW - 1)));
`endif

  function automatic logic [O_BW-1:0] reduce_out(input acc_t a);
    acc_t s;
    s = a >>> SHIFT;
`ifdef MFCC_DCT_SAT_EN
    if (s > OUT_MAX) s = OUT_MAX;
    else if (s < OUT_MIN) s = OUT_MIN;
`endif
    return O_BW'(s);
  endfunction

  logic [N_BW-1:0]   r_n;
  logic [K_BW-1:0]   r_k;
  acc_t              r_acc  [NUM_COEF];
  acc_t              r_bank [NUM_COEF];
  drain_state_e      r_state;
  logic [K_BW-1:0]   r_drainIdx;
  logic [O_BW-1:0]   r_data;
  logic              r_valid;
  logic              r_last;

  logic              w_beat;
  logic              w_frameEnd;
  logic [COEF_BW-1:0] w_coefRaw;
  coef_t             w_coef;
  logic signed [I_BW:0] w_x;
  acc_t              w_prod;
  acc_t              w_accNext [NUM_COEF];
  drain_state_e      w_stateNext;
  logic [K_BW-1:0]   w_drainIdxNext;
  logic [O_BW-1:0]   w_dataNext;
  logic              w_validNext;
  logic              w_lastNext;

  mfcc_dct_coef_rom u_rom (
    .i_k    (r_k),
    .i_n    (r_n),
    .o_coef (w_coefRaw)
  );

  assign w_coef     = coef_t'(w_coefRaw);
  assign w_beat     = en_i & valid_i;
  assign w_frameEnd = w_beat & (r_k == K_LAST) & ((r_n == N_LAST) | last_i);
  assign w_x        = signed'({1'b0, data_i});
  assign w_prod     = acc_t'(w_x) * acc_t'(w_coef);

  always_comb begin
    for (int i = 0; i < NUM_COEF; i++) begin
      w_accNext[i] = r_acc[i];
      if (w_beat && (r_k == K_BW'(i))) w_accNext[i] = r_acc[i] + w_prod;
    end
  end

  // Frame end hands the completed sums (this beat included) to the drain bank.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_n <= '0;
      r_k <= '0;
      for (int i = 0; i < NUM_COEF; i++) begin
        r_acc[i]  <= '0;
        r_bank[i] <= '0;
      end
    end else if (w_beat) begin
      if (w_frameEnd) begin
        r_n <= '0;
        r_k <= '0;
        for (int i = 0; i < NUM_COEF; i++) begin
          r_acc[i]  <= '0;
          r_bank[i] <= w_accNext[i];
        end
      end else begin
        for (int i = 0; i < NUM_COEF; i++) r_acc[i] <= w_accNext[i];
        if (r_k == K_LAST) begin
          r_k <= '0;
          r_n <= r_n + N_BW'(1);
        end else begin
          r_k <= r_k + K_BW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= DRAIN_IDLE;
      r_drainIdx <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_drainIdx <= w_drainIdxNext;
      r_data     <= w_dataNext;
      r_valid    <= w_validNext;
      r_last     <= w_lastNext;
    end
  end

  // X[0] comes straight from the next-state sums so it appears the cycle after frame end.
  always_comb begin
    w_stateNext    = r_state;
    w_drainIdxNext = r_drainIdx;
    w_dataNext     = r_data;
    w_validNext    = r_valid;
    w_lastNext     = r_last;
    if (en_i) begin
      if (w_frameEnd) begin
        w_stateNext    = DRAIN_BUSY;
        w_drainIdxNext = K_BW'(1);
        w_dataNext     = reduce_out(w_accNext[0]);
        w_validNext    = 1'b1;
        w_lastNext     = 1'b0;
      end else if (r_state == DRAIN_BUSY) begin
        if (r_drainIdx == K_DONE) begin
          w_stateNext = DRAIN_IDLE;
          w_validNext = 1'b0;
          w_lastNext  = 1'b0;
        end else begin
          w_dataNext     = reduce_out(r_bank[r_drainIdx]);
          w_validNext    = 1'b1;
          w_lastNext     = (r_drainIdx == K_LAST);
          w_drainIdxNext = r_drainIdx + K_BW'(1);
        end
      end
    end
  end

  assign data_o  = r_data;
  assign valid_o = r_valid & en_i;
  assign last_o  = r_last & en_i;

endmodule

// File: tb/tb_mfcc_dct.sv
// Directed bench for mfcc_dct: frames are driven beat by beat while a real-valued
// DCT reference pushes expected coefficients into a queue drained by a monitor.
module tb_mfcc_dct;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic [7:0]  data_i;
  logic        valid_i;
  logic        last_i;
  logic [15:0] data_o;
  logic        valid_o;
  logic        last_o;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } exp_t;

  exp_t expQ[$];
  int   frameX[32];
  int   errors = 0;
  int   checks = 0;
  logic [15:0] held;

  localparam real PI = 3.14159265358979323846;

  mfcc_dct dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (en_i),
    .data_i  (data_i),
    .valid_i (valid_i),
    .last_i  (last_i),
    .data_o  (data_o),
    .valid_o (valid_o),
    .last_o  (last_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference DCT-II using real cosines, rounded half away from zero.
  function automatic void pushFrame(input int nSamples);
    longint sum;
    longint s;
    int     c;
    exp_t   e;
    for (int k = 0; k < 13; k++) begin
      sum = 0;
      for (int n = 0; n < nSamples; n++) begin
        c = int'(127.0 * $cos(PI * real'(k * (2 * n + 1)) / 64.0));
        sum += longint'(frameX[n]) * longint'(c);
      end
      s = sum >>> 4;
`ifdef MFCC_DCT_SAT_EN
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
`endif
      e.data = s[15:0];
      e.last = (k == 12);
      expQ.push_back(e);
    end
  endfunction

  // Drives nSamples inputs, each held 13 beats; gapAt inserts 5 disabled cycles.
  task automatic applyStimulus(input int nSamples, input int gapAt);
    pushFrame(nSamples);
    for (int n = 0; n < nSamples; n++) begin
      for (int k = 0; k < 13; k++) begin
        data_i  = 8'(frameX[n]);
        valid_i = 1'b1;
        last_i  = (n == nSamples - 1);
        if (n * 13 + k == gapAt) begin
          en_i = 1'b0;
          repeat (5) cycle();
          en_i = 1'b1;
        end
        cycle();
      end
    end
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic waitDrain();
    for (int b = 0; b < 80 && expQ.size() != 0; b++) @(negedge clk_i);
    checkOutput("drain_complete", 32'(expQ.size()), 32'd0);
    cycle();
    @(negedge clk_i);
    checkOutput("valid_after_drain", 32'(valid_o), 32'd0);
    cycle();
  endtask

  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_i && valid_o) begin
      checkOutput("output_expected", 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput("coef_data", 32'(data_o), 32'(e.data));
        checkOutput("coef_last", 32'(last_o), 32'(e.last));
      end
    end
  end

  initial begin
    rst_i = 1'b1; en_i = 1'b1; valid_i = 1'b0; last_i = 1'b0; data_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("reset_data", 32'(data_o), 32'd0);
    checkOutput("reset_valid", 32'(valid_o), 32'd0);
    checkOutput("reset_last", 32'(last_o), 32'd0);
    cycle();
    rst_i = 1'b0;

    $display("[TB] zero frame");
    foreach (frameX[n]) frameX[n] = 0;
    applyStimulus(32, -1);
    waitDrain();

    $display("[TB] impulse at x[0]");
    frameX[0] = 16;
    applyStimulus(32, -1);
    waitDrain();

    $display("[TB] constant 100, then back-to-back early-last frame");
    foreach (frameX[n]) frameX[n] = 100;
    applyStimulus(32, -1);
    foreach (frameX[n]) frameX[n] = (n * 7 + 3) % 256;
    applyStimulus(10, -1);
    waitDrain();

    $display("[TB] constant 255");
    foreach (frameX[n]) frameX[n] = 255;
    applyStimulus(32, -1);
    waitDrain();

    $display("[TB] random frame");
    foreach (frameX[n]) frameX[n] = int'($urandom_range(0, 255));
    applyStimulus(32, -1);
    waitDrain();

    $display("[TB] enable gaps mid-frame and mid-drain");
    foreach (frameX[n]) frameX[n] = 100;
    applyStimulus(32, 200);
    repeat (3) cycle();
    held = data_o;
    en_i = 1'b0;
    repeat (5) begin
      @(negedge clk_i);
      checkOutput("gap_valid_low", 32'(valid_o), 32'd0);
      checkOutput("gap_data_hold", 32'(data_o), 32'(held));
      cycle();
    end
    en_i = 1'b1;
    waitDrain();

    $display("[TB] reset mid-frame then clean frame");
    for (int b = 0; b < 100; b++) begin
      data_i  = 8'd200;
      valid_i = 1'b1;
      cycle();
    end
    valid_i = 1'b0;
    rst_i   = 1'b1;
    @(negedge clk_i);
    checkOutput("midreset_data", 32'(data_o), 32'd0);
    checkOutput("midreset_valid", 32'(valid_o), 32'd0);
    cycle();
    rst_i = 1'b0;
    cycle();
    foreach (frameX[n]) frameX[n] = 100;
    applyStimulus(32, -1);
    waitDrain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
